mat_wb: RTL and testbench

- Result writeback engine for the matrix datapath.
- matCtrl feeds the Macs array from memory. This block takes the other direction: it collects the four 16-bit Macs result lanes and writes them back as packed 64-bit words.
- Write addresses are sequential, starting from a base given in a command.
- A small FIFO absorbs the result stream while the shared memory write port is not granted.

---
 rtl/mat_wb_pkg.sv | 20 ++
 rtl/mat_wb_if.sv | 34 +++
 rtl/mat_wb_fifo.sv | 45 ++++
 rtl/mat_wb.sv | 164 ++++++++++++++++
 tb/tb_mat_wb.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_wb_pkg.sv
// rtl/mat_wb_pkg.sv - shared defaults, word type and state encoding for the result writeback engine
package mat_pkg;

    localparam int MAT_ADDR_WIDTH = 12;
    localparam int MAT_LANE_WIDTH = 16;
    localparam int MAT_NUM_LANES  = 4;

    // Lane 0 occupies the least significant bits of a packed memory word
    localparam bit LANE0_AT_LSB = 1'b1;

    typedef logic [MAT_NUM_LANES*MAT_LANE_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/mat_wb_if.sv
// rtl/mat_wb_if.sv - command, result-lane and memory-write bundle of the writeback engine
interface mat_wb_if #(
    parameter int ADDR_WIDTH = mat_pkg::MAT_ADDR_WIDTH,
    parameter int LANE_WIDTH = mat_pkg::MAT_LANE_WIDTH
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_base_addr;
    logic [ADDR_WIDTH-1:0]   cmd_count;
    logic                    macs_valid;
    logic [LANE_WIDTH-1:0]   D_data_0;
    logic [LANE_WIDTH-1:0]   D_data_1;
    logic [LANE_WIDTH-1:0]   D_data_2;
    logic [LANE_WIDTH-1:0]   D_data_3;
    logic                    mem_grant;
    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [4*LANE_WIDTH-1:0] mem_wr_data;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    modport master (
        output cmd_valid, cmd_base_addr, cmd_count, macs_valid,
               D_data_0, D_data_1, D_data_2, D_data_3, mem_grant,
        input  cmd_ready, mem_wr_en, mem_addr, mem_wr_data, busy, done, overflow
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_count, macs_valid,
               D_data_0, D_data_1, D_data_2, D_data_3, mem_grant,
        output cmd_ready, mem_wr_en, mem_addr, mem_wr_data, busy, done, overflow
    );
endinterface

// File: rtl/mat_wb_fifo.sv
// rtl/mat_wb_fifo.sv - synchronous result buffer with full/empty flags and simultaneous push/pop
module mat_wb_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    // Pointer advance; a push into a full buffer is accepted only alongside a pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mat_wb.sv
// rtl/mat_wb.sv - result writeback engine; defining MAT_WB_MODQ_EN masks each lane to LOG_Q bits before buffering
module mat_wb #(
    parameter int ADDR_WIDTH = mat_pkg::MAT_ADDR_WIDTH,
    parameter int LANE_WIDTH = mat_pkg::MAT_LANE_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int LOG_Q      = 15
) (
    input  logic     clk,
    input  logic     rstn,
    mat_wb_if.slave  bus
);
    import mat_pkg::*;

    localparam int WORD_WIDTH = MAT_NUM_LANES * LANE_WIDTH;
    localparam int CW         = ADDR_WIDTH + 1;

`ifdef MAT_WB_MODQ_EN
    localparam int MASK_BITS = LOG_Q;
`else
    // LOG_Q has no effect in this build; the mask keeps every lane bit
    localparam int MASK_BITS = LANE_WIDTH + 0 * LOG_Q;
`endif
    localparam logic [LANE_WIDTH-1:0] LANE_MASK = LANE_WIDTH'((64'd1 << MASK_BITS) - 64'd1);

    wb_state_t state;
    wb_state_t state_next;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] rcv_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] drop_cnt;
    logic                  overflow_q;
    logic                  done_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WORD_WIDTH-1:0] push_word;
    logic [WORD_WIDTH-1:0] head_word;
    logic                  accept_cmd;
    logic                  beat_take;
    logic                  beat_drop;
    logic [CW-1:0]         settled;

    logic [LANE_WIDTH-1:0] lane_0;
    logic [LANE_WIDTH-1:0] lane_1;
    logic [LANE_WIDTH-1:0] lane_2;
    logic [LANE_WIDTH-1:0] lane_3;

    assign lane_0    = bus.D_data_0 & LANE_MASK;
    assign lane_1    = bus.D_data_1 & LANE_MASK;
    assign lane_2    = bus.D_data_2 & LANE_MASK;
    assign lane_3    = bus.D_data_3 & LANE_MASK;
    assign push_word = LANE0_AT_LSB ? {lane_3, lane_2, lane_1, lane_0}
                                    : {lane_0, lane_1, lane_2, lane_3};

    mat_wb_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rstn),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rstn) state <= IDLE;
        else      state <= state_next;
    end

    // Next state, beat acceptance and drop decision; completion counts the pop happening now
    // so that done follows the final write by one cycle
    always_comb begin
        state_next = state;
        accept_cmd = 1'b0;
        beat_take  = 1'b0;
        beat_drop  = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = !fifo_empty && bus.mem_grant;
        settled    = CW'(wr_cnt) + CW'(drop_cnt) + CW'(fifo_pop);
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept_cmd = 1'b1;
                    state_next = (bus.cmd_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (bus.macs_valid && (rcv_cnt < count_q)) begin
                    beat_take = 1'b1;
                    if (fifo_full && !fifo_pop) beat_drop = 1'b1;
                    else                        fifo_push = 1'b1;
                    if ((CW'(rcv_cnt) + CW'(1)) == CW'(count_q)) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (settled == CW'(count_q)) state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, counters, sticky overflow, registered write port and done pulse
    always_ff @(posedge clk) begin
        if (rstn) begin
            base_q     <= '0;
            count_q    <= '0;
            rcv_cnt    <= '0;
            wr_cnt     <= '0;
            drop_cnt   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (accept_cmd) begin
                base_q     <= bus.cmd_base_addr;
                count_q    <= bus.cmd_count;
                rcv_cnt    <= '0;
                wr_cnt     <= '0;
                drop_cnt   <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (beat_take) rcv_cnt <= rcv_cnt + 1'b1;
                if (beat_drop) begin
                    drop_cnt   <= drop_cnt + 1'b1;
                    overflow_q <= 1'b1;
                end
                if (fifo_pop) wr_cnt <= wr_cnt + 1'b1;
            end
            wr_en_q <= fifo_pop;
            if (fifo_pop) begin
                addr_q  <= base_q + wr_cnt;
                wdata_q <= head_word;
            end
            done_q <= (state == FIN);
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.busy        = (state == RUN) || (state == DRAIN);
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;
endmodule

// File: tb/tb_mat_wb.sv
// tb/tb_mat_wb.sv - self-checking bench for mat_wb with a queue-based reference model
module tb_mat_wb;
    import mat_pkg::*;

    localparam int AW    = 12;
    localparam int LW    = 16;
    localparam int DEPTH = 4;
    localparam int LOGQ  = 15;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   passes = 0;
    bit   cmp_en = 1'b0;

    mat_wb_if #(.ADDR_WIDTH(AW), .LANE_WIDTH(LW)) bus ();

    mat_wb #(
        .ADDR_WIDTH (AW),
        .LANE_WIDTH (LW),
        .FIFO_DEPTH (DEPTH),
        .LOG_Q      (LOGQ)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic word_t pack(logic [LW-1:0] l0, logic [LW-1:0] l1,
                                   logic [LW-1:0] l2, logic [LW-1:0] l3);
        logic [63:0] m;
`ifdef MAT_WB_MODQ_EN
        m = (64'd1 << LOGQ) - 64'd1;
`else
        m = (64'd1 << LW) - 64'd1;
`endif
        return word_t'(l0 & m) + (word_t'(l1 & m) << LW)
             + (word_t'(l2 & m) << (2*LW)) + (word_t'(l3 & m) << (3*LW));
    endfunction

    // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 finishing
    word_t          mq[$];
    int             m_phase = 0;
    logic [AW-1:0]  m_base  = '0;
    int             m_count = 0;
    int             m_rcv   = 0;
    int             m_wr    = 0;
    int             m_drop  = 0;
    logic           m_ovf   = 1'b0;
    logic           e_wr_en = 1'b0;
    logic           e_done  = 1'b0;
    logic [AW-1:0]  e_addr  = '0;
    word_t          e_data  = '0;

    always @(posedge clk) begin
        bit pop;
        bit was_full;
        if (rstn) begin
            mq.delete();
            m_phase = 0; m_rcv = 0; m_wr = 0; m_drop = 0; m_count = 0; m_base = '0;
            m_ovf = 1'b0; e_wr_en = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop      = (mq.size() != 0) && (bus.mem_grant === 1'b1);
            e_done   = (m_phase == 3);
            if (pop) begin
                e_wr_en = 1'b1;
                e_addr  = AW'(int'(m_base) + m_wr);
                e_data  = mq.pop_front();
                m_wr++;
            end else begin
                e_wr_en = 1'b0;
            end
            case (m_phase)
                0: if (bus.cmd_valid === 1'b1) begin
                       m_base = bus.cmd_base_addr; m_count = int'(bus.cmd_count);
                       m_rcv = 0; m_wr = 0; m_drop = 0; m_ovf = 1'b0;
                       m_phase = (m_count == 0) ? 3 : 1;
                   end
                1: if (bus.macs_valid === 1'b1 && m_rcv < m_count) begin
                       m_rcv++;
                       if (was_full && !pop) begin
                           m_drop++;
                           m_ovf = 1'b1;
                       end else begin
                           mq.push_back(pack(bus.D_data_0, bus.D_data_1, bus.D_data_2, bus.D_data_3));
                       end
                       if (m_rcv == m_count) m_phase = 2;
                   end
                2: if (m_wr + m_drop == m_count) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmd_ready",   bus.cmd_ready,   64'(m_phase == 0));
            check("busy",        bus.busy,        64'(m_phase == 1 || m_phase == 2));
            check("done",        bus.done,        64'(e_done));
            check("overflow",    bus.overflow,    64'(m_ovf));
            check("mem_wr_en",   bus.mem_wr_en,   64'(e_wr_en));
            check("mem_addr",    bus.mem_addr,    64'(e_addr));
            check("mem_wr_data", bus.mem_wr_data, 64'(e_data));
        end
    end

    // Write and done log for the directed literal checks
    int             wlog_cyc[$];
    logic [AW-1:0]  wlog_addr[$];
    word_t          wlog_data[$];
    int             dlog[$];

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            wlog_cyc.push_back(cyc);
            wlog_addr.push_back(bus.mem_addr);
            wlog_data.push_back(bus.mem_wr_data);
        end
        if (bus.done === 1'b1) dlog.push_back(cyc);
    end

    function automatic logic [63:0] addr_at(int i);
        return (i < wlog_addr.size()) ? 64'(wlog_addr[i]) : '1;
    endfunction
    function automatic logic [63:0] data_at(int i);
        return (i < wlog_data.size()) ? 64'(wlog_data[i]) : '1;
    endfunction
    function automatic int wcyc_at(int i);
        return (i < wlog_cyc.size()) ? wlog_cyc[i] : -1000;
    endfunction
    function automatic int dcyc_at(int i);
        return (i < dlog.size()) ? dlog[i] : -1000;
    endfunction

    task automatic clear_logs();
        wlog_cyc.delete(); wlog_addr.delete(); wlog_data.delete(); dlog.delete();
    endtask

    task automatic set_beat(bit v, logic [LW-1:0] a, logic [LW-1:0] b, logic [LW-1:0] c, logic [LW-1:0] d);
        bus.macs_valid = v;
        bus.D_data_0 = a; bus.D_data_1 = b; bus.D_data_2 = c; bus.D_data_3 = d;
    endtask

    task automatic send_cmd(logic [AW-1:0] base, logic [AW-1:0] cnt, output int acc);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_base_addr = base; bus.cmd_count = cnt;
        acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(int limit);
        int n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", bus.done, 1);
    endtask

    task automatic beats_seq(int n, int first);
        for (int i = 0; i < n; i++) begin
            set_beat(1'b1, LW'(first + 4*i), LW'(first + 4*i + 1), LW'(first + 4*i + 2), LW'(first + 4*i + 3));
            @(negedge clk);
        end
        bus.macs_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int acc;
        int bcyc;
        int gp;
        word_t d;
        bus.cmd_valid = 1'b0; bus.cmd_base_addr = '0; bus.cmd_count = '0;
        bus.mem_grant = 1'b0;
        set_beat(1'b0, '0, '0, '0, '0);
        rstn = 1'b1;
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_en", bus.mem_wr_en, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_wr_data, 0);
        check("rst_done_ovf", {bus.done, bus.overflow}, 0);
        rstn = 1'b0;
        @(negedge clk);

        // Basic writeback
        clear_logs();
        bus.mem_grant = 1'b1;
        send_cmd(12'h010, 12'd3, acc);
        bcyc = cyc;
        beats_seq(3, 1);
        wait_done(50);
        @(negedge clk);
        check("basic_nwrites", 64'(wlog_addr.size()), 3);
        check("basic_addr0", addr_at(0), 64'h010);
        check("basic_addr1", addr_at(1), 64'h011);
        check("basic_addr2", addr_at(2), 64'h012);
        check("basic_data0", data_at(0), 64'h0004_0003_0002_0001);
        check("basic_data1", data_at(1), 64'h0008_0007_0006_0005);
        check("basic_data2", data_at(2), 64'h000C_000B_000A_0009);
        check("basic_latency", 64'(wcyc_at(0) - bcyc), 2);
        check("basic_done_gap", 64'(dcyc_at(0) - wcyc_at(2)), 1);

        // Backpressure
        clear_logs();
        bus.mem_grant = 1'b0;
        send_cmd(12'h100, 12'd4, acc);
        beats_seq(4, 16);
        @(negedge clk);
        check("bp_no_write_low_grant", 64'(wlog_addr.size()), 0);
        bus.mem_grant = 1'b1;
        wait_done(50);
        @(negedge clk);
        check("bp_nwrites", 64'(wlog_addr.size()), 4);
        check("bp_consecutive", 64'(wcyc_at(3) - wcyc_at(0)), 3);
        check("bp_addr3", addr_at(3), 64'h103);
        check("bp_data3", data_at(3), 64'h001F_001E_001D_001C);
        check("bp_overflow", bus.overflow, 0);

        // Overflow: beats 5 and 6 are dropped
        clear_logs();
        bus.mem_grant = 1'b0;
        send_cmd(12'h200, 12'd6, acc);
        beats_seq(6, 32);
        check("ovf_set", bus.overflow, 1);
        bus.mem_grant = 1'b1;
        wait_done(50);
        @(negedge clk);
        check("ovf_nwrites", 64'(wlog_addr.size()), 4);
        check("ovf_data3", data_at(3), 64'h002F_002E_002D_002C);
        check("ovf_sticky", bus.overflow, 1);

        // Address wrap; accepting this command clears overflow
        clear_logs();
        send_cmd(12'hFFE, 12'd3, acc);
        check("ovf_cleared", bus.overflow, 0);
        beats_seq(3, 100);
        wait_done(50);
        @(negedge clk);
        check("wrap_addr0", addr_at(0), 64'hFFE);
        check("wrap_addr1", addr_at(1), 64'hFFF);
        check("wrap_addr2", addr_at(2), 64'h000);

        // Zero count
        clear_logs();
        send_cmd(12'h055, 12'd0, acc);
        wait_done(20);
        @(negedge clk);
        check("zero_done_latency", 64'(dcyc_at(0) - acc), 2);
        check("zero_no_writes", 64'(wlog_addr.size()), 0);

        // Reset after two of four words are written
        clear_logs();
        send_cmd(12'h300, 12'd4, acc);
        for (int i = 0; i < 4; i++) begin
            set_beat(1'b1, LW'(200 + i), '0, '0, '0);
            if (i == 3) rstn = 1'b1;
            @(negedge clk);
        end
        rstn = 1'b0;
        bus.macs_valid = 1'b0;
        check("mid_rst_writes_before", 64'(wlog_addr.size()), 2);
        check("mid_rst_ready", bus.cmd_ready, 1);
        check("mid_rst_outputs", {bus.busy, bus.mem_wr_en, bus.done, bus.overflow}, 0);
        check("mid_rst_addr_data", {4'h0, bus.mem_addr, bus.mem_wr_data[47:0]}, 0);
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", 64'(dlog.size()), 0);
        check("mid_rst_no_more_writes", 64'(wlog_addr.size()), 2);
        clear_logs();
        send_cmd(12'h010, 12'd3, acc);
        beats_seq(3, 1);
        wait_done(50);
        @(negedge clk);
        check("post_rst_data2", data_at(2), 64'h000C_000B_000A_0009);

        // Lane reduction
        clear_logs();
        send_cmd(12'h020, 12'd1, acc);
        set_beat(1'b1, 16'hFFFF, 16'h1234, 16'hABCD, 16'h0001);
        @(negedge clk);
        bus.macs_valid = 1'b0;
        wait_done(50);
        @(negedge clk);
        d = word_t'(data_at(0));
`ifdef MAT_WB_MODQ_EN
        check("modq_lane0", 64'(d[15:0]), 64'h7FFF);
`else
        check("modq_lane0", 64'(d[15:0]), 64'hFFFF);
`endif

        // Randomized commands, beats and grant
        for (int t = 0; t < 30; t++) begin
            int n;
            gp = int'($urandom_range(20, 100));
            send_cmd(AW'($urandom), AW'($urandom_range(0, 9)), acc);
            n = 0;
            while (bus.done !== 1'b1 && n < 400) begin
                bus.mem_grant = ($urandom_range(0, 99) < gp);
                set_beat($urandom_range(0, 99) < 70, LW'($urandom), LW'($urandom), LW'($urandom), LW'($urandom));
                @(negedge clk);
                n++;
            end
            check("rand_done", bus.done, 1);
        end
        bus.macs_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
